adder_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared clocked `adder` in the CPU datapath. It accepts operand pairs over a valid/ready handshake and drives them onto the single adder. It waits out the adder's pipeline latency, then returns the sum to the requester that issued it. Only one operation is in flight at a time.

---
 rtl/adder_arb_pkg.sv | 20 ++
 rtl/rr_pick2.sv | 20 ++
 rtl/adder_arbiter.sv | 136 +++++++++++++
 tb/tb_adder_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg
// Shared definitions for the adder arbiter: FSM state encoding, default
// operand width and adder latency (also used by the CPU top), and a small
// helper that turns a requester index into a one-hot pair.
package adder_arb_pkg;

    localparam int DEF_WIDTH       = 4;
    localparam int DEF_ADD_LATENCY = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } arb_state_e;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// rr_pick2
// Combinational two-way round-robin pick. A lone valid requester always
// wins; when both are valid, prio names the winner.
// Ports:
//   req_valid[1:0]  in   requests
//   prio            in   requester favoured on a tie
//   grant[1:0]      out  one-hot grant (all zero when nothing is valid)
module rr_pick2 (
    input  logic [1:0] req_valid,
    input  logic       prio,
    output logic [1:0] grant
);

    always_comb begin
        grant    = 2'b00;
        grant[0] = req_valid[0] & (~req_valid[1] | ~prio);
        grant[1] = req_valid[1] & (~req_valid[0] |  prio);
    end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter
// Two-requester round-robin front end for the shared pipelined adder. One
// operation is in flight at a time: accept operands, wait out the adder
// latency, hand the sum back to the requester that issued it.
// Ports:
//   clock, reset_n             clock and synchronous active-low reset
//   req_valid/req_ready[1:0]   operand handshake per requester
//   req_a0/req_b0/req_a1/req_b1 operands per requester
//   rsp_valid/rsp_ready[1:0]   response handshake per requester
//   rsp_sum                    result, meaningful while a rsp_valid bit is high
//   add_a, add_b, add_sum      registered operands to / result from the adder
//   busy                       high whenever the FSM is not idle
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | waiting for a request; grant is offered combinationally
// ST_WAIT    | operands on the adder, counting down the adder latency
// ST_RESPOND | sum held for the owner until it takes it
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int ADD_LATENCY = DEF_ADD_LATENCY
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_sum,
    output logic             busy
);

    localparam int CNT_W = 3;

    arb_state_e       state_q, state_d;
    logic             owner_q, owner_d;
    logic             prio_q, prio_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic [WIDTH-1:0] rsp_sum_q, rsp_sum_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [1:0]       grant;

    rr_pick2 u_pick (
        .req_valid (req_valid),
        .prio      (prio_q),
        .grant     (grant)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        prio_d      = prio_q;
        cnt_d       = cnt_q;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_valid_d = rsp_valid_q;
        req_ready   = 2'b00;

        case (state_q)
            ST_IDLE: begin
                // No grant is offered while reset is held.
                req_ready   = grant & {2{reset_n}};
                rsp_valid_d = 2'b00;
                if (|(req_valid & req_ready)) begin
                    owner_d = grant[1];
                    add_a_d = grant[1] ? req_a1 : req_a0;
                    add_b_d = grant[1] ? req_b1 : req_b0;
                    cnt_d   = CNT_W'(ADD_LATENCY);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    rsp_sum_d   = add_sum;
                    rsp_valid_d = onehot2(owner_q);
                    state_d     = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                // Only the owner's ready matters; the other bit is ignored.
                if (rsp_ready[owner_q]) begin
                    rsp_valid_d = 2'b00;
                    prio_d      = ~owner_q;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                rsp_valid_d = 2'b00;
                state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            prio_q      <= 1'b0;
            cnt_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            rsp_sum_q   <= '0;
            rsp_valid_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            prio_q      <= prio_d;
            cnt_q       <= cnt_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter
// Three arbiter instances (adder latency 1, 0 and 3), each with its own
// delayed adder model. Inputs are driven and outputs sampled 1ns after the
// falling clock edge.
module tb_adder_arbiter;

    localparam int LAT [3] = '{1, 0, 3};

    logic       clock = 1'b0;
    logic       reset_n   [3];
    logic [1:0] req_valid [3];
    logic [1:0] req_ready [3];
    logic [3:0] ra0 [3], rb0 [3], ra1 [3], rb1 [3];
    logic [1:0] rsp_valid [3];
    logic [1:0] rsp_ready [3];
    logic [3:0] rsp_sum [3];
    logic [3:0] add_a [3], add_b [3], add_sum [3];
    logic       busy [3];
    logic [3:0] pipe [3][3];

    int checks = 0;
    int errors = 0;
    int mprio [3];

    always #5 clock = ~clock;

    adder_arbiter #(.WIDTH(4), .ADD_LATENCY(1)) u_dut_l1 (
        .clock(clock), .reset_n(reset_n[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_a0(ra0[0]), .req_b0(rb0[0]), .req_a1(ra1[0]), .req_b1(rb1[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_sum(rsp_sum[0]),
        .add_a(add_a[0]), .add_b(add_b[0]), .add_sum(add_sum[0]), .busy(busy[0]));

    adder_arbiter #(.WIDTH(4), .ADD_LATENCY(0)) u_dut_l0 (
        .clock(clock), .reset_n(reset_n[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_a0(ra0[1]), .req_b0(rb0[1]), .req_a1(ra1[1]), .req_b1(rb1[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_sum(rsp_sum[1]),
        .add_a(add_a[1]), .add_b(add_b[1]), .add_sum(add_sum[1]), .busy(busy[1]));

    adder_arbiter #(.WIDTH(4), .ADD_LATENCY(3)) u_dut_l3 (
        .clock(clock), .reset_n(reset_n[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_a0(ra0[2]), .req_b0(rb0[2]), .req_a1(ra1[2]), .req_b1(rb1[2]),
        .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_sum(rsp_sum[2]),
        .add_a(add_a[2]), .add_b(add_b[2]), .add_sum(add_sum[2]), .busy(busy[2]));

    // Adder models: a delay line of (a+b) mod 16, tapped at each latency.
    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            pipe[i][0] <= add_a[i] + add_b[i];
            pipe[i][1] <= pipe[i][0];
            pipe[i][2] <= pipe[i][1];
        end
    end

    always_comb begin
        add_sum[0] = pipe[0][0];
        add_sum[1] = add_a[1] + add_b[1];
        add_sum[2] = pipe[2][2];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    // One full transaction on instance i. The granted requester is predicted
    // from the model's fairness pointer; exp_sum < 0 means "compute from the
    // granted operands". d = cycles the owner withholds rsp_ready.
    task automatic do_op(input int i, input logic [1:0] v,
                         input logic [3:0] xa0, input logic [3:0] xb0,
                         input logic [3:0] xa1, input logic [3:0] xb1,
                         input int exp_sum, input int d);
        int g, n, es;
        logic [3:0] ea, eb, held;
        g  = (v == 2'b01) ? 0 : (v == 2'b10) ? 1 : mprio[i];
        ea = (g == 1) ? xa1 : xa0;
        eb = (g == 1) ? xb1 : xb0;
        es = (exp_sum < 0) ? (int'(ea) + int'(eb)) % 16 : exp_sum;

        ra0[i] = xa0; rb0[i] = xb0; ra1[i] = xa1; rb1[i] = xb1;
        req_valid[i] = v;
        rsp_ready[i] = 2'b11;
        rsp_ready[i][g] = (d == 0);
        #1;
        chk("grant", int'(req_ready[i]), 1 << g);
        step();
        req_valid[i] = 2'b00;
        #1;
        chk("busy_wait", int'(busy[i]), 1);
        chk("ready_wait", int'(req_ready[i]), 0);
        chk("add_a", int'(add_a[i]), int'(ea));
        chk("add_b", int'(add_b[i]), int'(eb));

        n = 0;
        while (rsp_valid[i] == 2'b00 && n < 20) begin
            step();
            n++;
        end
        chk("latency", n, LAT[i] + 1);
        chk("rsp_valid", int'(rsp_valid[i]), 1 << g);
        chk("rsp_sum", int'(rsp_sum[i]), es);
        held = rsp_sum[i];

        // The other requester knocks during the response; it must wait.
        req_valid[i] = 2'(1 << (1 - g));
        #1;
        chk("ready_respond", int'(req_ready[i]), 0);
        for (int j = 0; j < d; j++) begin
            step();
            chk("stall_valid", int'(rsp_valid[i]), 1 << g);
            chk("stall_sum", int'(rsp_sum[i]), int'(held));
            chk("stall_busy", int'(busy[i]), 1);
            chk("stall_ready", int'(req_ready[i]), 0);
        end
        rsp_ready[i][g] = 1'b1;
        step();
        chk("done_busy", int'(busy[i]), 0);
        chk("done_valid", int'(rsp_valid[i]), 0);
        chk("hold_add_a", int'(add_a[i]), int'(ea));
        chk("other_granted", int'(req_ready[i]), 1 << (1 - g));
        req_valid[i] = 2'b00;
        rsp_ready[i] = 2'b00;
        mprio[i] = 1 - g;
    endtask

    typedef struct {
        int         k;
        logic [3:0] a;
        logic [3:0] b;
        int         exp_sum;
        int         d;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ng, nr, viol, cyc, quiet;
        int gq[$], gc[$], rq[$];

        vecs[0] = '{0, 4'b0011, 4'b0001, 4,  0};
        vecs[1] = '{1, 4'b1001, 4'b0111, 0,  0};
        vecs[2] = '{0, 4'd15,   4'd15,   14, 5};
        vecs[3] = '{1, 4'd8,    4'd8,    0,  2};
        vecs[4] = '{0, 4'd0,    4'd0,    0,  0};
        vecs[5] = '{1, 4'd10,   4'd3,    13, 1};

        for (int i = 0; i < 3; i++) begin
            reset_n[i] = 1'b0; req_valid[i] = 2'b00; rsp_ready[i] = 2'b00;
            ra0[i] = '0; rb0[i] = '0; ra1[i] = '0; rb1[i] = '0;
            mprio[i] = 0;
        end

        // Contention from reset: both valid all the time, zero-wait consumers.
        req_valid[0] = 2'b11; rsp_ready[0] = 2'b11;
        ra0[0] = 4'd2; rb0[0] = 4'd5; ra1[0] = 4'd6; rb1[0] = 4'd12;
        repeat (3) step();
        chk("rst_ready", int'(req_ready[0]), 0);
        chk("rst_busy", int'(busy[0]), 0);
        chk("rst_rsp_valid", int'(rsp_valid[0]), 0);
        chk("rst_add_a", int'(add_a[0]), 0);
        chk("rst_rsp_sum", int'(rsp_sum[0]), 0);
        for (int i = 0; i < 3; i++) reset_n[i] = 1'b1;
        #1;

        nr = 0; viol = 0; cyc = 0;
        while (nr < 4 && cyc < 60) begin
            if (req_ready[0] == 2'b11) viol++;
            if (req_ready[0] == 2'b01) begin gq.push_back(0); gc.push_back(cyc); end
            if (req_ready[0] == 2'b10) begin gq.push_back(1); gc.push_back(cyc); end
            if (rsp_valid[0] != 2'b00) begin
                rq.push_back(rsp_valid[0] == 2'b10 ? 1 : 0);
                chk("cont_sum", int'(rsp_sum[0]), (rsp_valid[0] == 2'b10) ? 2 : 7);
                nr++;
                if (nr == 4) req_valid[0] = 2'b00;
            end
            step();
            cyc++;
        end
        chk("cont_responses", nr, 4);
        chk("cont_both_ready", viol, 0);
        ng = gq.size();
        if (ng >= 4 && rq.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("cont_grant_order", gq[k], k % 2);
                chk("cont_rsp_order", rq[k], k % 2);
            end
            chk("cont_spacing", gc[1] - gc[0], LAT[0] + 3);
        end else begin
            chk("cont_grant_count", ng, 4);
        end
        chk("cont_idle", int'(busy[0]), 0);
        mprio[0] = 0;

        // Directed vector table on the latency-1 instance.
        for (int t = 0; t < 6; t++) begin
            logic [3:0] ja, jb;
            ja = 4'($urandom_range(0, 15));
            jb = 4'($urandom_range(0, 15));
            if (vecs[t].k == 0)
                do_op(0, 2'b01, vecs[t].a, vecs[t].b, ja, jb, vecs[t].exp_sum, vecs[t].d);
            else
                do_op(0, 2'b10, ja, jb, vecs[t].a, vecs[t].b, vecs[t].exp_sum, vecs[t].d);
        end

        // Reset in WAIT: point prio at requester 1 first, then abort its op.
        do_op(0, 2'b01, 4'd1, 4'd1, 4'd0, 4'd0, 2, 0);
        req_valid[0] = 2'b10; ra1[0] = 4'd5; rb1[0] = 4'd6; rsp_ready[0] = 2'b11;
        step();
        req_valid[0] = 2'b00;
        chk("abort_in_wait", int'(busy[0]), 1);
        reset_n[0] = 1'b0;
        step();
        req_valid[0] = 2'b11;
        #1;
        chk("abort_ready_in_reset", int'(req_ready[0]), 0);
        chk("abort_busy", int'(busy[0]), 0);
        chk("abort_rsp_valid", int'(rsp_valid[0]), 0);
        chk("abort_add_a", int'(add_a[0]), 0);
        chk("abort_add_b", int'(add_b[0]), 0);
        req_valid[0] = 2'b00;
        reset_n[0] = 1'b1;
        quiet = 0;
        for (int j = 0; j < 8; j++) begin
            step();
            if (rsp_valid[0] != 2'b00) quiet++;
        end
        chk("abort_no_response", quiet, 0);
        req_valid[0] = 2'b11;
        #1;
        chk("abort_prio_reset", int'(req_ready[0]), 1);
        req_valid[0] = 2'b00;
        rsp_ready[0] = 2'b00;
        mprio[0] = 0;
        step();

        // Randomized operations on all three latencies.
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 25; n++) begin
                do_op(i, 2'($urandom_range(1, 3)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      -1, int'($urandom_range(0, 3)));
                if ($urandom_range(0, 1) == 1) step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
